// File: rtl/option_queue_if.sv
// Bus bundle between the board parser/solver and the option queue.
interface option_queue_if #(
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            load_valid;
  logic [SIZE-1:0] load_data;
  logic            load_done;
  logic            push_back;
  logic [SIZE-1:0] push_data;
  logic            pop;
  logic            solved;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            started;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            halted;

  // Parser/solver side drives requests and observes the queue.
  modport master (
    output load_valid, load_data, load_done, push_back, push_data, pop, solved,
    input  out_data, out_valid, started, count, full, empty, overflow, halted
  );

  // Queue side.
  modport slave (
    input  load_valid, load_data, load_done, push_back, push_data, pop, solved,
    output out_data, out_valid, started, count, full, empty, overflow, halted
  );
endinterface

// File: rtl/option_queue.sv
// Option queue: circular FIFO that is loaded by the parser, then fed
// and drained by the solver until the board is solved or runs dry.
module option_queue #(
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  option_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic            started_q;
  logic            overflow_q;

  logic            wr_req;
  logic [SIZE-1:0] wr_data;
  logic            wr_ok;
  logic            rd_ok;
  logic            is_full;
  logic            is_empty;

  // Select the write source by phase and qualify write/pop against occupancy.
  always_comb begin
    wr_req  = 1'b0;
    wr_data = bus.load_data;
    case (state)
      S_IDLE, S_LOAD: wr_req = bus.load_valid;
      S_RUN: begin
        wr_req  = bus.push_back;
        wr_data = bus.push_data;
      end
      default: wr_req = 1'b0;
    endcase
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == CW'(0));
    rd_ok    = (state == S_RUN) && !is_empty && bus.pop;
    // A pop in the same cycle frees the slot a full-queue write needs.
    wr_ok    = wr_req && (!is_full || rd_ok);
  end

  // Buffer storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Phase FSM, pointers, occupancy and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      started_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      started_q <= 1'b0;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_req && !wr_ok) begin
        overflow_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.load_valid) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.load_done) begin
            if (!is_empty || wr_ok) begin
              state     <= S_RUN;
              started_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (bus.solved || (is_empty && !bus.push_back)) begin
            state <= S_DONE;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  // Status decode from registered state; head is first-word-fall-through.
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = (state == S_RUN) && !is_empty;
  assign bus.started   = started_q;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;
  assign bus.halted    = (state == S_DONE);
endmodule

// File: doc/option_queue.md
OPTION_QUEUE -- requirements
Module: option_queue

Interface
REQ-001 Parameter SIZE, default 3, line width in cells; each entry is SIZE bits.
REQ-002 Parameter DEPTH, default 64, queue capacity in entries; power of two, at least 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 load_valid  input  1  parser entry strobe during board load.
REQ-006 load_data  input  SIZE  parser entry, either a line index or an option.
REQ-007 load_done  input  1  one-cycle pulse; parser has finished loading.
REQ-008 push_back  input  1  solver re-enqueue request (solver put_back_to_FIFO).
REQ-009 push_data  input  SIZE  entry to re-enqueue (solver new_option).
REQ-010 pop  input  1  solver consumes the head entry this cycle.
REQ-011 solved  input  1  solver reports board solved.
REQ-012 out_data  output  SIZE  head entry (first-word-fall-through).
REQ-013 out_valid  output  1  head is valid and the queue is in RUN.
REQ-014 started  output  1  one-cycle pulse on entry to RUN; drives solver started.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 full, empty  output  1 each  count==DEPTH and count==0.
REQ-017 overflow  output  1  sticky; an entry was dropped.
REQ-018 halted  output  1  queue in DONE state.

Function
REQ-019 States: IDLE, LOAD, RUN, DONE, encoded in a registered state variable.
- IDLE->LOAD on the first load_valid; that entry is written.
- LOAD->RUN on load_done when count>0 (counting a same-cycle load write); LOAD->IDLE on load_done when count==0.
- RUN->DONE when solved==1 or when count==0 with no same-cycle push_back.
- DONE->IDLE only on rst.
REQ-020 Storage is a DEPTH-entry circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-021 Write source:
- IDLE/LOAD: load_valid/load_data only; push_back is ignored.
- RUN: push_back/push_data only; load_valid is ignored.
- DONE: all writes ignored.
REQ-022 pop is honoured only in RUN with out_valid=1; otherwise it is ignored and the pointers do not move.
REQ-023 out_data equals mem[rd_ptr] combinationally; out_valid = (state==RUN) && !empty.
REQ-024 Write-to-visible latency: an entry written to an empty queue appears on out_data/out_valid the next cycle.
REQ-025 Simultaneous accepted write and pop: both pointers advance and count is unchanged.
REQ-026 Write when full:
- With a same-cycle accepted pop, the write is accepted.
- Otherwise the entry is dropped, pointers and count hold, and overflow is set to 1 until rst.
REQ-027 Write and pop on an empty queue in the same cycle: pop is ignored (out_valid=0) and the write is accepted.
REQ-028 started is 1 for exactly the cycle after the LOAD->RUN transition edge and 0 at all other times.
REQ-029 solved is sampled in every state; outside RUN it has no effect.
REQ-030 count is never negative and never exceeds DEPTH; it equals (wr_ptr - rd_ptr) modulo DEPTH, with count==DEPTH when the pointers are equal and full.
REQ-031 The queue preserves FIFO order across wrap-around; re-enqueued options follow the line-index entries already queued.

Reset
REQ-032 With rst=1 at a clock edge:
- state becomes IDLE; pointers and count become 0.
- out_valid, started, overflow and halted become 0; full becomes 0 and empty becomes 1.
- Buffer contents are not cleared.
REQ-033 Assertion of rst mid-LOAD or mid-RUN discards all queued entries; the next load sequence starts from pointer 0.
REQ-034 Outputs take their reset values in the cycle after the reset edge and are independent of other inputs while rst=1.

Verification
REQ-035 Load 3'b000, 3'b101, 3'b011, then pulse load_done -> started pulses once, out_valid=1, out_data=3'b000, count=3.
REQ-036 In RUN, pop and push_back 3'b101 together on every cycle for 2*DEPTH cycles -> count stays constant, entries emerge in order across wrap-around, overflow=0.
REQ-037 Fill to DEPTH, then push_back without pop -> entry dropped, count=DEPTH, overflow=1 until rst; repeat with a same-cycle pop -> entry accepted, overflow unchanged.
REQ-038 Empty queue in RUN, assert push_back 3'b110 with pop=1 -> pop ignored, next cycle out_data=3'b110, out_valid=1, count=1.
REQ-039 Assert solved in RUN with count=5 -> next cycle halted=1, out_valid=0, and further push_back/pop leave count=5.
REQ-040 Assert rst for one cycle mid-RUN with count=7 -> count=0, empty=1, state IDLE; reload of two entries plus load_done -> started pulses and out_data is the first new entry.
